// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents: bubble encoding, default reset PC, PC step, the 2-bit FSM state
// encoding and a helper that forces a target address to word alignment.
package if_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'b00,
    ST_FETCH    = 2'b01,
    ST_KILL     = 2'b10,
    ST_BUFFERED = 2'b11
  } fetch_state_e;

  // Redirect targets may carry junk in bits [1:0]; instructions are word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load_i          capture {valid=1, pc_i, pc_i+4, instr_i}
//   bubble_i        insert a bubble (valid=0, NOP); wins over load_i
//   pc_i, instr_i   instruction being handed to decode and its PC
//   valid_o, pc_o, pc4_o, instr_o   registered IF/ID contents
// Neither load_i nor bubble_i asserted means hold.
module if_fetch_stage_if_id_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;
  logic [31:0] instr_q;

  // IF/ID storage: bubble, load or hold. A bubble keeps the old PC fields;
  // only valid and the instruction word matter to decode for a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
    end else if (bubble_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      pc4_q   <= pc_i + PC_STEP;
      instr_q <= instr_i;
    end else begin
      valid_q <= valid_q;
      pc_q    <= pc_q;
      pc4_q   <= pc4_q;
      instr_q <= instr_q;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with PC, fetch FSM and IF/ID register.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall                   hold IF/ID and PC (load-use hazard)
//   flush, redirect_pc      taken control transfer in EX and its target
//   imem_req, imem_addr     fetch request; held stable until imem_ready
//   imem_ready, imem_rdata  fetch response
//   if_id_valid/pc/pc4/instr  IF/ID register contents for decode
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pend_q;   // redirect target waiting for the killed fetch to return
  logic [31:0]  buf_q;    // instruction returned while decode was stalled
  logic         req_q;

  logic         ifid_load_s;
  logic         ifid_bubble_s;
  logic [31:0]  ifid_instr_s;

  // IF/ID control: flush beats stall; stall holds; otherwise load or bubble.
  always_comb begin
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    ifid_instr_s  = imem_rdata;
    if (flush) begin
      ifid_bubble_s = 1'b1;
    end else if (stall) begin
      ifid_bubble_s = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            ifid_load_s = 1'b1;
          end else begin
            ifid_bubble_s = 1'b1;
          end
        end
        ST_BUFFERED: begin
          ifid_load_s  = 1'b1;
          ifid_instr_s = buf_q;
        end
        default: ifid_bubble_s = 1'b1;
      endcase
    end
  end

  // Fetch FSM, PC, pending redirect, stall buffer and registered request.
  // The PC doubles as the fetch address, so it must not move while a
  // request is outstanding; a flush during that time parks in pend_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0000_0000;
      buf_q   <= NOP_INSTR;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
          if (flush) pc_q <= align_pc(redirect_pc);
        end
        ST_FETCH: begin
          if (imem_ready) begin
            if (flush) begin
              pc_q <= align_pc(redirect_pc);
            end else if (stall) begin
              buf_q   <= imem_rdata;
              state_q <= ST_BUFFERED;
              req_q   <= 1'b0;
            end else begin
              pc_q <= pc_q + PC_STEP;
            end
          end else if (flush) begin
            pend_q  <= align_pc(redirect_pc);
            state_q <= ST_KILL;
          end
        end
        ST_KILL: begin
          if (imem_ready) begin
            // Response is discarded; the newest redirect wins.
            pc_q    <= flush ? align_pc(redirect_pc) : pend_q;
            state_q <= ST_FETCH;
          end else if (flush) begin
            pend_q <= align_pc(redirect_pc);
          end
        end
        ST_BUFFERED: begin
          if (flush) begin
            pc_q    <= align_pc(redirect_pc);
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end else if (!stall) begin
            pc_q    <= pc_q + PC_STEP;
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;

  if_fetch_stage_if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ifid_load_s),
    .bubble_i (ifid_bubble_s),
    .pc_i     (pc_q),
    .instr_i  (ifid_instr_s),
    .valid_o  (if_id_valid),
    .pc_o     (if_id_pc),
    .pc4_o    (if_id_pc4),
    .instr_o  (if_id_instr)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;

  int    n_vec = 0;
  int    n_err = 0;
  ifid_t sb_q[$];
  logic  last_stall = 1'b0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr)
  );

  // Instruction memory contents: fixed word at 0x10, address-derived elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  assign imem_rdata = mem_fn(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the IF/ID contents expected after the upcoming accept of pc.
  task automatic expect_ifid(input logic [31:0] pc, input logic [31:0] instr);
    ifid_t e;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.instr = instr;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) last_stall <= stall;

  // Monitor: every non-stalled edge that leaves IF/ID valid is a new entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_id_valid === 1'b1 && last_stall === 1'b0) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ifid: got pc %h instr %h expected no valid entry", if_id_pc, if_id_instr);
      end else begin
        ifid_t e;
        e = sb_q.pop_front();
        if (if_id_pc !== e.pc || if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          n_err++;
          $display("FAIL ifid_entry: got {%h,%h,%h} expected {%h,%h,%h}",
                   if_id_pc, if_id_pc4, if_id_instr, e.pc, e.pc4, e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    // BOOT cycle: reset values, no request.
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc",    if_id_pc, 32'h0);
    chk("rst_pc4",   if_id_pc4, 32'h0);
    step();
    chk("boot_req", {31'd0, imem_req}, 32'd1);

    // Streaming with ready always high.
    for (int i = 0; i < 2; i++) begin
      chk("stream_addr", imem_addr, 32'(i * 4));
      expect_ifid(32'(i * 4), mem_fn(32'(i * 4)));
      step();
    end

    // Three wait states at 0x8.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      step();
      chk("wait_bubble", {31'd0, if_id_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    expect_ifid(32'h8, mem_fn(32'h8));
    step();
    chk("after_wait_addr", imem_addr, 32'hC);
    expect_ifid(32'hC, mem_fn(32'hC));
    step();

    // Stall when 0x10 returns: buffered, request dropped.
    chk("buf_addr", imem_addr, 32'h10);
    stall = 1'b1;
    step();
    chk("buf_req0", {31'd0, imem_req}, 32'd0);
    chk("buf_hold_pc", if_id_pc, 32'hC);
    step();
    chk("buf_req1", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    expect_ifid(32'h10, 32'h0050_0093);
    step();
    chk("unbuf_req", {31'd0, imem_req}, 32'd1);
    chk("unbuf_addr", imem_addr, 32'h14);
    for (int i = 0; i < 3; i++) begin
      expect_ifid(32'(32'h14 + i * 4), mem_fn(32'(32'h14 + i * 4)));
      step();
    end

    // Flush to 0x40 while fetch of 0x20 is pending.
    chk("kill_start_addr", imem_addr, 32'h20);
    imem_ready = 1'b0; flush = 1'b1; redirect_pc = 32'h40;
    step();
    flush = 1'b0;
    chk("kill_bubble", {31'd0, if_id_valid}, 32'd0);
    chk("kill_addr0", imem_addr, 32'h20);
    step();
    chk("kill_addr1", imem_addr, 32'h20);
    imem_ready = 1'b1;
    step();
    chk("kill_redirect_addr", imem_addr, 32'h40);
    expect_ifid(32'h40, mem_fn(32'h40));
    step();

    // Flush and stall together; misaligned target.
    flush = 1'b1; stall = 1'b1; redirect_pc = 32'h103;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("fs_valid", {31'd0, if_id_valid}, 32'd0);
    chk("fs_instr", if_id_instr, NOP);
    chk("fs_addr", imem_addr, 32'h100);
    expect_ifid(32'h100, mem_fn(32'h100));
    step();

    // PC wrap at the top of the address space.
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    expect_ifid(32'hFFFF_FFFC, mem_fn(32'hFFFF_FFFC));
    step();
    chk("wrap_addr1", imem_addr, 32'h0);

    // Enter KILL, then assert reset asynchronously mid-cycle.
    imem_ready = 1'b0; flush = 1'b1; redirect_pc = 32'h200;
    step();
    flush = 1'b0;
    chk("kill2_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("arst_instr", if_id_instr, NOP);
    chk("arst_pc",    if_id_pc, 32'h0);
    chk("arst_pc4",   if_id_pc4, 32'h0);
    chk("arst_addr",  imem_addr, 32'h0);
    imem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("reboot_addr", imem_addr, 32'h0);
    chk("reboot_req", {31'd0, imem_req}, 32'd1);
    expect_ifid(32'h0, mem_fn(32'h0));
    step();
    imem_ready = 1'b0;
    step();
    step();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
